alu_issue_stage: RTL and testbench

Operand-issue stage directly upstream of the ALU. Holds the 32×32-bit register file and a per-register busy scoreboard, and accepts operate commands over a valid/ready handshake. Each accepted command's operands are read and registered onto outputs that wire straight to the ALU's `aluSrc1`, `aluSrc2`, `invertA`, `invertB` and `operation` inputs. The ALU result returns through a write-back port that updates the register file and releases the destination register.

---
 rtl/alu_issue_stage.sv | 110 +++++++++++
 tb/tb_alu_issue_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of the ALU: register file, busy scoreboard, one-entry ex_* output register.
// Define ISSUE_FWD_EN to let a same-cycle write-back clear hazards and bypass wb_data into operands.
module alu_issue_stage #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [3:0]        cmd_ctrl,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_src1,
  output logic [DATA_W-1:0] ex_src2,
  output logic              ex_invertA,
  output logic              ex_invertB,
  output logic [1:0]        ex_operation,
  output logic [4:0]        ex_rd,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_ex_valid;
  logic [DATA_W-1:0]   r_ex_src1, r_ex_src2;
  logic [3:0]          r_ex_ctrl;
  logic [4:0]          r_ex_rd;

  logic [NUM_REGS-1:0] w_wb_clr, w_set, w_busy_eff;
  logic [DATA_W-1:0]   w_src1, w_src2;
  logic                w_hazard, w_accept;

  // Index 0 is excluded from both masks, so B[0] stays 0 and R[0] is never written.
  always_comb begin
    w_wb_clr = '0;
    w_set    = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_wb_clr[i] = wb_en && (wb_rd == 5'(i));
      w_set[i]    = w_accept && (cmd_rd == 5'(i));
    end
  end

`ifdef ISSUE_FWD_EN
  assign w_busy_eff = r_busy & ~w_wb_clr;
`else
  assign w_busy_eff = r_busy;
`endif

  assign w_hazard  = ((cmd_rs != 5'd0) && w_busy_eff[cmd_rs]) ||
                     ((cmd_rt != 5'd0) && w_busy_eff[cmd_rt]) ||
                     ((cmd_rd != 5'd0) && w_busy_eff[cmd_rd]);
  assign cmd_ready = (!r_ex_valid || ex_ready) && !w_hazard;
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    w_src1 = r_regs[cmd_rs];
    w_src2 = r_regs[cmd_rt];
`ifdef ISSUE_FWD_EN
    if (wb_en && (wb_rd == cmd_rs)) w_src1 = wb_data;
    if (wb_en && (wb_rd == cmd_rt)) w_src2 = wb_data;
`endif
    if (cmd_rs == 5'd0) w_src1 = '0;
    if (cmd_rt == 5'd0) w_src2 = '0;
  end

  // Issue's set is OR'd after the write-back clear so the set wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_wb_clr[i]) r_regs[i] <= wb_data;
      r_busy <= (r_busy & ~w_wb_clr) | w_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_src1  <= '0;
      r_ex_src2  <= '0;
      r_ex_ctrl  <= '0;
      r_ex_rd    <= '0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
      r_ex_src1  <= w_src1;
      r_ex_src2  <= w_src2;
      r_ex_ctrl  <= cmd_ctrl;
      r_ex_rd    <= cmd_rd;
    end else if (ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_src1      = r_ex_src1;
  assign ex_src2      = r_ex_src2;
  assign ex_invertA   = r_ex_ctrl[3];
  assign ex_invertB   = r_ex_ctrl[2];
  assign ex_operation = r_ex_ctrl[1:0];
  assign ex_rd        = r_ex_rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scenarios followed by randomized traffic, all checked against a register/scoreboard model.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, ex_valid, ex_ready, wb_en;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd, ex_rd, wb_rd;
  logic [3:0]  cmd_ctrl;
  logic [31:0] ex_src1, ex_src2, wb_data;
  logic        ex_invertA, ex_invertB;
  logic [1:0]  ex_operation;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_ctrl(cmd_ctrl),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_invertA(ex_invertA), .ex_invertB(ex_invertB), .ex_operation(ex_operation),
    .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register values, pending-write set, and the ALU-facing slot.
  logic [31:0] m_R [32];
  bit          m_B [32];
  bit          m_ev;
  logic [31:0] m_s1, m_s2;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rd;

  function automatic bit m_pending(input logic [4:0] i);
    if (i == 0) return 0;
    if (FWD && wb_en && wb_rd == i) return 0;
    return m_B[i];
  endfunction

  function automatic bit m_ready();
    return (!m_ev || ex_ready) && !m_pending(cmd_rs) && !m_pending(cmd_rt) && !m_pending(cmd_rd);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] i);
    if (i == 0) return 32'd0;
    if (FWD && wb_en && wb_rd == i) return wb_data;
    return m_R[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check cmd_ready before the edge, advance the model on the edge, check ex_* after it.
  task automatic cyc();
    bit acc;
    logic [31:0] a, b;
    #1;
    if (!rst) chk("cmd_ready", cmd_ready, m_ready());
    acc = !rst && cmd_valid && m_ready();
    a = m_read(cmd_rs);
    b = m_read(cmd_rt);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_R[i] = 0; m_B[i] = 0; end
      m_ev = 0; m_s1 = 0; m_s2 = 0; m_ctrl = 0; m_rd = 0;
    end else begin
      if (wb_en && wb_rd != 0) begin m_R[wb_rd] = wb_data; m_B[wb_rd] = 0; end
      if (acc) begin
        m_ev = 1; m_s1 = a; m_s2 = b; m_ctrl = cmd_ctrl; m_rd = cmd_rd;
        if (cmd_rd != 0) m_B[cmd_rd] = 1;
      end else if (ex_ready) m_ev = 0;
    end
    #1;
    chk("ex_valid", ex_valid, m_ev);
    chk("ex_src1", ex_src1, m_s1);
    chk("ex_src2", ex_src2, m_s2);
    chk("ex_ctrl", {ex_invertA, ex_invertB, ex_operation}, m_ctrl);
    chk("ex_rd", ex_rd, m_rd);
  endtask

  task automatic cmd(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [3:0] c);
    cmd_valid = v; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_ctrl = c;
  endtask

  task automatic wb(input bit en, input logic [4:0] rd, input logic [31:0] d);
    wb_en = en; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    logic [31:0] h1, h2;
    rst = 1; ex_ready = 1;
    cmd(1, 5'd1, 5'd2, 5'd4, 4'hF);
    wb(1, 5'd2, 32'hAAAA_AAAA);
    cyc();
    cyc();
    rst = 0; cmd(0, 0, 0, 0, 0); wb(0, 0, 0);
    #1 chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_ex_valid", ex_valid, 1'b0);

    // First issue from r0
    cmd(1, 5'd0, 5'd0, 5'd3, 4'b0010);
    cyc();
    chk("first_valid", ex_valid, 1'b1);
    chk("first_op", ex_operation, 2'b10);
    chk("first_rd", ex_rd, 5'd3);
    cmd(0, 5'd3, 5'd0, 5'd0, 0);
    #1 chk("busy3_blocks", cmd_ready, 1'b0);

    cmd(0, 0, 0, 0, 0);
    wb(1, 5'd3, 32'h0);          cyc();
    wb(1, 5'd5, 32'h0000_00FF);  cyc();
    wb(1, 5'd6, 32'hFFFF_FF01);  cyc();
    wb(0, 0, 0);
    cmd(1, 5'd5, 5'd6, 5'd7, 4'b1001);
    cyc();
    chk("rd_src1", ex_src1, 32'h0000_00FF);
    chk("rd_src2", ex_src2, 32'hFFFF_FF01);

    // RAW on r7 until its write-back
    cmd(1, 5'd7, 5'd0, 5'd8, 4'b0100);
    #1 chk("raw_block", cmd_ready, 1'b0);
    cyc();
    wb(1, 5'd7, 32'h1234_5678);
`ifdef ISSUE_FWD_EN
    #1 chk("fwd_ready", cmd_ready, 1'b1);
    cyc();
`else
    #1 chk("nofwd_wait", cmd_ready, 1'b0);
    cyc();
    wb(0, 0, 0);
    #1 chk("nofwd_ready", cmd_ready, 1'b1);
    cyc();
`endif
    wb(0, 0, 0);
    chk("dep_src1", ex_src1, 32'h1234_5678);
    chk("dep_rd", ex_rd, 5'd8);

    // Back-pressure: hold for 3 cycles, then release with no bubble
    cmd(1, 5'd5, 5'd6, 5'd9, 4'b0011);
    cyc();
    h1 = ex_src1; h2 = ex_src2;
    ex_ready = 0;
    cmd(1, 5'd5, 5'd0, 5'd10, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", cmd_ready, 1'b0);
      cyc();
      chk("stall_src1", ex_src1, h1);
      chk("stall_src2", ex_src2, h2);
      chk("stall_rd", ex_rd, 5'd9);
    end
    ex_ready = 1;
    #1 chk("release_ready", cmd_ready, 1'b1);
    cyc();
    chk("release_valid", ex_valid, 1'b1);
    chk("release_src1", ex_src1, 32'h0000_00FF);
    chk("release_rd", ex_rd, 5'd10);

    // Write-back to r0 is dropped
    cmd(0, 0, 0, 0, 0);
    wb(1, 5'd0, 32'hDEAD_BEEF);
    cyc();
    wb(0, 0, 0);
    cmd(1, 5'd0, 5'd0, 5'd0, 4'b0000);
    cyc();
    chk("r0_src1", ex_src1, 32'h0);

    // Reset mid-flight with r9 still pending
    ex_ready = 0; cmd(0, 0, 0, 0, 0);
    rst = 1;
    cyc();
    rst = 0; ex_ready = 1;
    cmd(1, 5'd9, 5'd0, 5'd11, 4'b0110);
    #1 chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_valid", ex_valid, 1'b0);
    cyc();
    chk("post_rst_src1", ex_src1, 32'h0);
    chk("post_rst_issue", ex_valid, 1'b1);

    // Randomized traffic on a narrow register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(99, 0) == 0);
      ex_ready = ($urandom_range(3, 0) != 0);
      cmd($urandom_range(1, 0), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
          5'($urandom_range(7, 0)), 4'($urandom));
      wb($urandom_range(1, 0), 5'($urandom_range(7, 0)), $urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
